// File: rtl/minmax_tracker.sv
// Frame-based running min/max/count tracker with valid/ready handshakes on both sides.
// A frame is a run of accepted beats closed by in_last; its result is held until taken.

module comp_n #(
   parameter int DW = 32
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic          lt,
   output logic          gt
);
   assign lt = (a < b);
   assign gt = (a > b);
endmodule

module minmax_tracker #(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_min,
   output logic [DW-1:0] out_max,
   output logic [CW-1:0] out_cnt,
   output logic          out_eq_all
);
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t        state;
   logic [DW-1:0] run_min;
   logic [DW-1:0] run_max;
   logic [CW-1:0] run_cnt;
   logic          run_eq;

   logic          lt_min, gt_min, lt_max, gt_max;
   logic          accept;
   logic [DW-1:0] min_next;
   logic [DW-1:0] max_next;
   logic [CW-1:0] cnt_next;
   logic          eq_next;

   comp_n #(.DW(DW)) u_cmp_min (.a(in_data), .b(run_min), .lt(lt_min), .gt(gt_min));
   comp_n #(.DW(DW)) u_cmp_max (.a(in_data), .b(run_max), .lt(lt_max), .gt(gt_max));

   assign in_ready  = (state != HOLD);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;

   // First beat of a frame seeds everything; later beats fold into the running values.
   always_comb begin
      min_next = run_min;
      max_next = run_max;
      cnt_next = run_cnt;
      eq_next  = run_eq;
      if (state == IDLE) begin
         min_next = in_data;
         max_next = in_data;
         cnt_next = CW'(1);
         eq_next  = 1'b1;
      end else begin
         if (lt_min) min_next = in_data;
         if (gt_max) max_next = in_data;
         if (run_cnt != {CW{1'b1}}) cnt_next = run_cnt + CW'(1);
         eq_next = run_eq && !(lt_min || gt_min || lt_max || gt_max);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         run_min    <= '0;
         run_max    <= '0;
         run_cnt    <= '0;
         run_eq     <= 1'b0;
         out_min    <= '0;
         out_max    <= '0;
         out_cnt    <= '0;
         out_eq_all <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  run_min <= min_next;
                  run_max <= max_next;
                  run_cnt <= cnt_next;
                  run_eq  <= eq_next;
                  if (in_last) begin
                     out_min    <= min_next;
                     out_max    <= max_next;
                     out_cnt    <= cnt_next;
                     out_eq_all <= eq_next;
                     state      <= HOLD;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker; a second instance with CW=3 shares the stimulus
// so count saturation can be observed on a short frame.

module tb_minmax_tracker;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, out_eq_all;
   logic [31:0] out_min, out_max;
   logic [15:0] out_cnt;

   logic        s_in_ready, s_out_valid, s_out_eq_all;
   logic [31:0] s_out_min, s_out_max;
   logic [2:0]  s_out_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   minmax_tracker #(.DW(32), .CW(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_min(out_min), .out_max(out_max), .out_cnt(out_cnt), .out_eq_all(out_eq_all)
   );

   minmax_tracker #(.DW(32), .CW(3)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_min(s_out_min), .out_max(s_out_max), .out_cnt(s_out_cnt), .out_eq_all(s_out_eq_all)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Present one beat before the edge; the beat is accepted if in_ready is high.
   task automatic send(input logic [31:0] data, input logic last);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_min", 64'(out_min), 64'd0);
      check("rst_max", 64'(out_max), 64'd0);
      check("rst_cnt", 64'(out_cnt), 64'd0);
      check("rst_eq", 64'(out_eq_all), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd1);

      // Mixed frame of four beats
      out_ready = 1'b1;
      send(32'h4afd5b6c, 1'b0);
      check("f1_acc_valid", 64'(out_valid), 64'd0);
      send(32'hf74a32ab, 1'b0);
      send(32'h325b63ff, 1'b0);
      send(32'h445832a3, 1'b1);
      check("f1_valid", 64'(out_valid), 64'd1);
      check("f1_min", 64'(out_min), 64'h325b63ff);
      check("f1_max", 64'(out_max), 64'hf74a32ab);
      check("f1_cnt", 64'(out_cnt), 64'd4);
      check("f1_eq", 64'(out_eq_all), 64'd0);
      check("f1_hold_rdy", 64'(in_ready), 64'd0);
      tick();
      check("f1_xfer_valid", 64'(out_valid), 64'd0);
      check("f1_bubble_rdy", 64'(in_ready), 64'd1);
      check("f1_retain_min", 64'(out_min), 64'h325b63ff);

      // Single all-ones beat, then back-pressure in HOLD
      out_ready = 1'b0;
      send(32'hffffffff, 1'b1);
      check("f2_valid", 64'(out_valid), 64'd1);
      check("f2_min", 64'(out_min), 64'hffffffff);
      check("f2_max", 64'(out_max), 64'hffffffff);
      check("f2_cnt", 64'(out_cnt), 64'd1);
      check("f2_eq", 64'(out_eq_all), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 32'h0000_0001;
         in_last  = 1'b1;
         tick();
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_ready", 64'(in_ready), 64'd0);
         check("hold_min", 64'(out_min), 64'hffffffff);
         check("hold_cnt", 64'(out_cnt), 64'd1);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      check("hold_xfer", 64'(out_valid), 64'd0);

      // Equal non-zero samples keep eq_all; one differing sample clears it
      send(32'h55, 1'b0);
      send(32'h55, 1'b0);
      send(32'h55, 1'b1);
      check("eq3_cnt", 64'(out_cnt), 64'd3);
      check("eq3_eq", 64'(out_eq_all), 64'd1);
      check("eq3_min", 64'(out_min), 64'h55);
      tick();
      send(32'h90, 1'b0);
      send(32'h30, 1'b0);
      send(32'h60, 1'b1);
      check("desc_min", 64'(out_min), 64'h30);
      check("desc_max", 64'(out_max), 64'h90);
      check("desc_eq", 64'(out_eq_all), 64'd0);
      tick();

      // Reset in the middle of a frame discards it
      send(32'h1234, 1'b0);
      send(32'h5678, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      send(32'h0, 1'b0);
      send(32'h0, 1'b1);
      check("z_valid", 64'(out_valid), 64'd1);
      check("z_min", 64'(out_min), 64'd0);
      check("z_max", 64'(out_max), 64'd0);
      check("z_cnt", 64'(out_cnt), 64'd2);
      check("z_eq", 64'(out_eq_all), 64'd1);
      tick();

      // Reset during HOLD drops out_valid without waiting for a clock edge
      out_ready = 1'b0;
      send(32'h77, 1'b1);
      check("ar_pre_valid", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", 64'(out_valid), 64'd0);
      check("ar_cnt", 64'(out_cnt), 64'd0);
      check("ar_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Nine beats 1..9: saturating count on the CW=3 instance
      for (int i = 1; i <= 9; i++) send(32'(i), (i == 9));
      check("sat_valid", 64'(s_out_valid), 64'd1);
      check("sat_cnt", 64'(s_out_cnt), 64'd7);
      check("sat_min", 64'(s_out_min), 64'd1);
      check("sat_max", 64'(s_out_max), 64'd9);
      check("sat_eq", 64'(s_out_eq_all), 64'd0);
      check("wide_cnt", 64'(out_cnt), 64'd9);
      tick();
      check("sat_xfer", 64'(s_out_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule
